// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding, default constants and load clamp helper
package countdown_timer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   localparam int unsigned DEF_WIDTH = 32;
   localparam longint unsigned DEF_INIT = 64;
   localparam longint unsigned DEF_END = 8;
   function automatic logic [63:0] clamp(input logic [63:0] value, input logic [63:0] lo, input logic [63:0] hi);
      return (value < lo) ? lo : (value > hi) ? hi : value;
   endfunction
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter from a start value to EndVal with start/stop and optional auto-reload
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned     Width      = DEF_WIDTH,
   parameter longint unsigned InitVal    = DEF_INIT,
   parameter longint unsigned EndVal     = DEF_END,
   parameter bit              AutoReload = 1'b0
) (
   input  logic             Clk_i,
   input  logic             Reset_i,
   input  logic             Start_i,
   input  logic             Stop_i,
   input  logic             LoadValid_i,
   input  logic [Width-1:0] LoadData_i,
   output logic             LoadReady_o,
   output logic [Width-1:0] Data_o,
   output logic             Busy_o,
   output logic             Done_o
);
   localparam logic [Width-1:0] LP_INIT = Width'(InitVal);
   localparam logic [Width-1:0] LP_END  = Width'(EndVal);
   if (!(EndVal < InitVal && (Width >= 64 || InitVal < (64'd1 << Width)))) begin : g_bad_params
      $error("countdown_timer: need EndVal < InitVal < 2**Width");
   end
   state_t           r_state;
   logic [Width-1:0] r_data;
   logic [Width-1:0] r_reload;
   logic             r_done;
   logic [Width-1:0] w_load;
   logic [Width-1:0] w_next;
   logic             w_hit;
   assign w_load = Width'(clamp(64'(LoadData_i), 64'(EndVal), 64'(InitVal)));
   // only reached at EndVal with auto-reload, since without it RUN exits to HOLD first
   assign w_next = (r_data == LP_END) ? r_reload : r_data - Width'(1);
   assign w_hit = (w_next == LP_END);
   assign LoadReady_o = (r_state != RUN);
   assign Busy_o = (r_state == RUN);
   assign Data_o = r_data;
   assign Done_o = r_done;
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         r_state  <= IDLE;
         r_data   <= LP_INIT;
         r_reload <= LP_INIT;
         r_done   <= 1'b0;
      end else if (LoadValid_i && r_state != RUN) begin
         r_state  <= IDLE;
         r_data   <= w_load;
         r_reload <= w_load;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= Start_i && (r_data <= LP_END);
               if (Start_i) r_state <= (r_data > LP_END) ? RUN : HOLD;
            end
            RUN: begin
               if (Stop_i) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end else begin
                  r_data <= w_next;
                  r_done <= w_hit;
                  if (w_hit && !AutoReload) r_state <= HOLD;
               end
            end
            default: r_done <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus on a plain and an auto-reload instance, checked against a rule model
module tb_countdown_timer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        lv = 1'b0;
   logic [31:0] ld = '0;
   logic [31:0] d0, d1;
   logic        rdy0, rdy1, busy0, busy1, done0, done1;
   int          tests = 0;
   int          fails = 0;
   int          m_cnt[2];
   int          m_rel[2];
   int          m_st[2];
   int          m_done[2];
   bit          m_ok = 1'b0;
   int          e5_data[6] = '{10, 9, 8, 10, 9, 8};
   bit          e5_done[6] = '{0, 0, 1, 0, 0, 1};

   always #5 clk = ~clk;

   countdown_timer #(.AutoReload(1'b0)) u0 (
      .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Stop_i(stop), .LoadValid_i(lv), .LoadData_i(ld),
      .LoadReady_o(rdy0), .Data_o(d0), .Busy_o(busy0), .Done_o(done0));
   countdown_timer #(.AutoReload(1'b1)) u1 (
      .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Stop_i(stop), .LoadValid_i(lv), .LoadData_i(ld),
      .LoadReady_o(rdy1), .Data_o(d1), .Busy_o(busy1), .Done_o(done1));

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic int clampv(input logic [31:0] v);
      return (v < 32'd8) ? 8 : (v > 32'd64) ? 64 : int'(v);
   endfunction

   // mode 0 idle, 1 counting, 2 finished; index 1 is the auto-reload instance
   function automatic int nxt(input int k);
      return (m_cnt[k] == 8) ? m_rel[k] : m_cnt[k] - 1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_cnt[k] <= 64; m_rel[k] <= 64; m_st[k] <= 0; m_done[k] <= 0;
         end else if (lv && m_st[k] != 1) begin
            m_cnt[k] <= clampv(ld); m_rel[k] <= clampv(ld); m_st[k] <= 0; m_done[k] <= 0;
         end else if (m_st[k] == 0) begin
            m_done[k] <= (start && m_cnt[k] <= 8) ? 1 : 0;
            if (start) m_st[k] <= (m_cnt[k] > 8) ? 1 : 2;
         end else if (m_st[k] == 1) begin
            if (stop) begin
               m_st[k] <= 0; m_done[k] <= 0;
            end else begin
               m_cnt[k] <= nxt(k);
               m_done[k] <= (nxt(k) == 8) ? 1 : 0;
               if (nxt(k) == 8 && k == 0) m_st[k] <= 2;
            end
         end else begin
            m_done[k] <= 0;
         end
      end
      if (rst) m_ok <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_data0", 64'(d0), 64'(m_cnt[0]));
         chk("model_done0", 64'(done0), 64'(m_done[0]));
         chk("model_busy0", 64'(busy0), 64'(m_st[0] == 1));
         chk("model_ready0", 64'(rdy0), 64'(m_st[0] != 1));
         chk("model_data1", 64'(d1), 64'(m_cnt[1]));
         chk("model_done1", 64'(done1), 64'(m_done[1]));
         chk("model_busy1", 64'(busy1), 64'(m_st[1] == 1));
         chk("model_ready1", 64'(rdy1), 64'(m_st[1] != 1));
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_data", 64'(d0), 64);
      chk("rst_ready", 64'(rdy0), 1);
      chk("rst_busy", 64'(busy0), 0);
      chk("rst_done", 64'(done0), 0);
      // full run 64..8
      start = 1'b1;
      repeat (57) @(negedge clk);
      chk("t1_end_data", 64'(d0), 8);
      chk("t1_end_done", 64'(done0), 1);
      chk("t1_end_busy", 64'(busy0), 0);
      repeat (3) @(negedge clk);
      chk("t1_hold_data", 64'(d0), 8);
      chk("t1_hold_done", 64'(done0), 0);
      // load 20 then run
      start = 1'b0; lv = 1'b1; ld = 32'd20;
      @(negedge clk);
      lv = 1'b0;
      chk("t2_load", 64'(d0), 20);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t2_run_data", 64'(d0), 20);
      chk("t2_run_ready", 64'(rdy0), 0);
      repeat (12) @(negedge clk);
      chk("t2_end_data", 64'(d0), 8);
      chk("t2_end_done", 64'(done0), 1);
      // clamping
      lv = 1'b1; ld = 32'd3;
      @(negedge clk);
      chk("t3_clamp_lo", 64'(d0), 8);
      ld = 32'd100;
      @(negedge clk);
      chk("t3_clamp_hi", 64'(d0), 64);
      ld = 32'd0; start = 1'b1;
      @(negedge clk);
      lv = 1'b0; start = 1'b0;
      chk("t3_load_start_data", 64'(d0), 8);
      chk("t3_load_start_busy", 64'(busy0), 0);
      chk("t3_load_start_done", 64'(done0), 0);
      // stop and resume
      lv = 1'b1; ld = 32'd50;
      @(negedge clk);
      lv = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("t4_at40", 64'(d0), 40);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("t4_stop_data", 64'(d0), 40);
      chk("t4_stop_busy", 64'(busy0), 0);
      chk("t4_stop_ready", 64'(rdy0), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4_resume_data", 64'(d0), 40);
      @(negedge clk);
      chk("t4_resume_dec", 64'(d0), 39);
      // load refused in RUN, then reset mid-run
      lv = 1'b1; ld = 32'd12;
      @(negedge clk);
      lv = 1'b0;
      chk("t6_noload", 64'(d0), 38);
      repeat (8) @(negedge clk);
      chk("t6_at30", 64'(d0), 30);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_data", 64'(d0), 64);
      chk("t6_rst_busy", 64'(busy0), 0);
      chk("t6_rst_done", 64'(done0), 0);
      // auto-reload sequence
      lv = 1'b1; ld = 32'd10;
      @(negedge clk);
      lv = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("t5_ar_data", 64'(d1), 64'(e5_data[i]));
         chk("t5_ar_done", 64'(done1), 64'(e5_done[i]));
         @(negedge clk);
      end
      chk("t5_plain_hold", 64'(d0), 8);
      // start with count already at EndVal
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; lv = 1'b1; ld = 32'd8;
      @(negedge clk);
      lv = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t7_done0", 64'(done0), 1);
      chk("t7_done1", 64'(done1), 1);
      chk("t7_busy1", 64'(busy1), 0);
      @(negedge clk);
      chk("t7_done0_after", 64'(done0), 0);
      chk("t7_data1", 64'(d1), 8);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
